// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the physical-memory line responder.
// Package pmem_types: FSM state encoding and default line/beat geometry.
package pmem_types;

    localparam int PMEM_LINE_W      = 256;
    localparam int PMEM_BEAT_W      = 64;
    localparam int PMEM_BEATS       = PMEM_LINE_W / PMEM_BEAT_W;
    localparam int PMEM_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_beat_buffer.sv
// Line-wide holding register: beat-indexed write port fills read lines,
// beat-indexed read mux feeds write bursts.
module pmem_beat_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line_next,
    output logic [BEAT_W-1:0] beat_out
);

    logic [LINE_W-1:0] line_q;

    // line_next exposes the post-write line so the last read beat can be
    // committed to the output register on the same edge it arrives.
    always_comb begin
        line_next = line_q;
        if (load) begin
            line_next = load_line;
        end else if (beat_we) begin
            line_next[int'(beat_idx) * BEAT_W +: BEAT_W] = beat_data;
        end
    end

    assign beat_out = line_q[int'(beat_idx) * BEAT_W +: BEAT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_next;
        end
    end

endmodule

// File: rtl/pmem_line_responder.sv
// L2 line-port responder: turns 256-bit line reads/writes into 4-beat bursts.
// Optional watchdog enabled by defining PMEM_LINE_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for line_read / line_write (read wins on a tie)
// RD_BURST | burst_read high, collecting beats into the line buffer
// WR_BURST | burst_write high, presenting latched line beat by beat
// DONE     | one-cycle line_resp, then back to IDLE
module pmem_line_responder
    import pmem_types::*;
#(
    parameter int LINE_W         = PMEM_LINE_W,
    parameter int BEAT_W         = PMEM_BEAT_W,
    parameter int BEATS          = LINE_W / BEAT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              line_err,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    pmem_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              beat_fire;
    logic              last_beat;
    logic              rd_last;
    logic              timeout;
    logic [LINE_W-1:0] buf_line_next;

    // Byte offset within the line is never forwarded to memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^line_address[PMEM_OFFSET_BITS-1:0];

    assign last_beat   = (cnt == CNT_W'(BEATS - 1));
    assign burst_read  = (state == RD_BURST);
    assign burst_write = (state == WR_BURST);
    assign line_resp   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        beat_fire  = 1'b0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                if (line_read || line_write) begin
                    accept     = 1'b1;
                    state_next = line_read ? RD_BURST : WR_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        rd_last    = 1'b1;
                        state_next = DONE;
                    end
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        state_next = DONE;
                    end
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            burst_address <= '0;
            line_rdata    <= '0;
        end else begin
            if (accept) begin
                burst_address <= {line_address[31:PMEM_OFFSET_BITS], {PMEM_OFFSET_BITS{1'b0}}};
                cnt           <= '0;
            end else if (beat_fire) begin
                cnt <= cnt + 1'b1;
            end
            if (rd_last) begin
                line_rdata <= buf_line_next;
            end else if (timeout && (state == RD_BURST)) begin
                line_rdata <= '0;
            end
        end
    end

    pmem_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_beat_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_line (line_wdata),
        .beat_we   (beat_fire && (state == RD_BURST)),
        .beat_idx  (cnt),
        .beat_data (burst_rdata),
        .line_next (buf_line_next),
        .beat_out  (burst_wdata)
    );

`ifdef PMEM_LINE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            in_burst;

    assign in_burst = (state == RD_BURST) || (state == WR_BURST);
    assign timeout  = in_burst && !burst_resp && (wd_cnt == '0);
    assign line_err = line_resp && err_q;

    // Down-counter reloads on acceptance and every beat; terminal count
    // with no beat on that cycle is the TIMEOUT_CYCLES-th silent cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            err_q  <= 1'b0;
        end else begin
            if (accept || burst_resp) begin
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if (in_burst && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout  = 1'b0;
    assign line_err = 1'b0;
`endif

endmodule
